// File: rtl/spi_game_tx.sv
// Transmit end of the game-state SPI link: packs ten fields into one frame
// on trigger and shifts it out MSB-first as SPI mode 0.
module spi_game_tx #(
    parameter int DATA_WIDTH      = 89,
    parameter int DATA_CLK_PERIOD = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [2:0]  health_in,
    input  logic [10:0] rect_x_in,
    input  logic [9:0]  rect_y_in,
    input  logic [10:0] rect_w_in,
    input  logic [9:0]  rect_h_in,
    input  logic [10:0] saber_x_in,
    input  logic [9:0]  saber_y_in,
    input  logic [1:0]  saber_state_in,
    input  logic [10:0] saber_attack_x_in,
    input  logic [9:0]  saber_attack_y_in,
    input  logic        trigger_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        chip_data_out,
    output logic        chip_clk_out,
    output logic        chip_sel_out
);
    localparam int HALF_PERIOD = DATA_CLK_PERIOD / 2;
    localparam int CYC_W       = (DATA_CLK_PERIOD > 2) ? $clog2(DATA_CLK_PERIOD) : 1;
    localparam int BIT_W       = $clog2(DATA_WIDTH);

    if (DATA_WIDTH != 89) begin : g_bad_width
        $error("spi_game_tx: DATA_WIDTH must be 89 to match the field layout");
    end
    if ((DATA_CLK_PERIOD < 2) || (DATA_CLK_PERIOD % 2 != 0)) begin : g_bad_period
        $error("spi_game_tx: DATA_CLK_PERIOD must be even and at least 2");
    end

    typedef enum logic {
        IDLE,
        TRANSMIT
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [CYC_W-1:0]        cyc_cnt, cyc_next;
    logic [BIT_W-1:0]        bit_cnt, bit_next;
    logic                    busy_next, done_next, data_next, sck_next, sel_next;
    logic [88:0]             frame;

    assign frame = {health_in, rect_x_in, rect_y_in, rect_w_in, rect_h_in,
                    saber_x_in, saber_y_in, saber_state_in,
                    saber_attack_x_in, saber_attack_y_in};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            chip_data_out <= 1'b0;
            chip_clk_out  <= 1'b0;
            chip_sel_out  <= 1'b1;
        end else begin
            state         <= state_next;
            cyc_cnt       <= cyc_next;
            bit_cnt       <= bit_next;
            busy_out      <= busy_next;
            done_out      <= done_next;
            chip_data_out <= data_next;
            chip_clk_out  <= sck_next;
            chip_sel_out  <= sel_next;
        end
    end

    // Frame payload carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk_in) begin
        shift_reg <= shift_next;
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cyc_next   = cyc_cnt;
        bit_next   = bit_cnt;
        busy_next  = busy_out;
        done_next  = 1'b0;
        data_next  = chip_data_out;
        sck_next   = chip_clk_out;
        sel_next   = chip_sel_out;

        unique case (state)
            IDLE: begin
                if (trigger_in) begin
                    shift_next = frame;
                    data_next  = frame[88];
                    sel_next   = 1'b0;
                    sck_next   = 1'b0;
                    busy_next  = 1'b1;
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (cyc_cnt == CYC_W'(DATA_CLK_PERIOD - 1)) begin
                    cyc_next = '0;
                    sck_next = 1'b0;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        sel_next   = 1'b1;
                        data_next  = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        // Rotate rather than shift so every register bit has a reader.
                        shift_next = {shift_reg[DATA_WIDTH-2:0], shift_reg[DATA_WIDTH-1]};
                        data_next  = shift_reg[DATA_WIDTH-2];
                        bit_next   = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cyc_next = cyc_cnt + CYC_W'(1);
                    if (cyc_cnt == CYC_W'(HALF_PERIOD - 1)) begin
                        sck_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_game_tx.sv
// Self-checking bench for spi_game_tx: table vectors, random frames against
// a field-layout model, and hand-written sequences for the timing corners.
`timescale 1ns/1ps
module tb_spi_game_tx;
    typedef struct {
        logic [2:0]  health;
        logic [10:0] rect_x;
        logic [9:0]  rect_y;
        logic [10:0] rect_w;
        logic [9:0]  rect_h;
        logic [10:0] saber_x;
        logic [9:0]  saber_y;
        logic [1:0]  saber_state;
        logic [10:0] attack_x;
        logic [9:0]  attack_y;
    } fields_t;

    typedef struct {
        fields_t    f;
        bit         p2;
        int         exp_ones;
        logic [2:0] exp_msb3;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in, trig8, trig2;
    logic [2:0]  health;
    logic [10:0] rect_x, rect_w, saber_x, attack_x;
    logic [9:0]  rect_y, rect_h, saber_y, attack_y;
    logic [1:0]  saber_state;
    logic        busy8, done8, data8, sck8, sel8;
    logic        busy2, done2, data2, sck2, sel2;
    logic        use2;
    logic        m_busy, m_done, m_data, m_clk, m_sel;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_in = ~clk_in;

    spi_game_tx #(.DATA_WIDTH(89), .DATA_CLK_PERIOD(8)) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .health_in(health), .rect_x_in(rect_x),
        .rect_y_in(rect_y), .rect_w_in(rect_w), .rect_h_in(rect_h), .saber_x_in(saber_x),
        .saber_y_in(saber_y), .saber_state_in(saber_state), .saber_attack_x_in(attack_x),
        .saber_attack_y_in(attack_y), .trigger_in(trig8), .busy_out(busy8), .done_out(done8),
        .chip_data_out(data8), .chip_clk_out(sck8), .chip_sel_out(sel8)
    );

    spi_game_tx #(.DATA_WIDTH(89), .DATA_CLK_PERIOD(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .health_in(health), .rect_x_in(rect_x),
        .rect_y_in(rect_y), .rect_w_in(rect_w), .rect_h_in(rect_h), .saber_x_in(saber_x),
        .saber_y_in(saber_y), .saber_state_in(saber_state), .saber_attack_x_in(attack_x),
        .saber_attack_y_in(attack_y), .trigger_in(trig2), .busy_out(busy2), .done_out(done2),
        .chip_data_out(data2), .chip_clk_out(sck2), .chip_sel_out(sel2)
    );

    assign m_busy = use2 ? busy2 : busy8;
    assign m_done = use2 ? done2 : done8;
    assign m_data = use2 ? data2 : data8;
    assign m_clk  = use2 ? sck2  : sck8;
    assign m_sel  = use2 ? sel2  : sel8;

    task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: each field weighted by the width of everything after it.
    function automatic logic [88:0] model_frame(input fields_t f);
        logic [88:0] w;
        w = 89'(f.health);
        w = w * 89'd2048 + 89'(f.rect_x);
        w = w * 89'd1024 + 89'(f.rect_y);
        w = w * 89'd2048 + 89'(f.rect_w);
        w = w * 89'd1024 + 89'(f.rect_h);
        w = w * 89'd2048 + 89'(f.saber_x);
        w = w * 89'd1024 + 89'(f.saber_y);
        w = w * 89'd4    + 89'(f.saber_state);
        w = w * 89'd2048 + 89'(f.attack_x);
        w = w * 89'd1024 + 89'(f.attack_y);
        return w;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.health = 3'($urandom);     f.rect_x = 11'($urandom);  f.rect_y = 10'($urandom);
        f.rect_w = 11'($urandom);    f.rect_h = 10'($urandom);  f.saber_x = 11'($urandom);
        f.saber_y = 10'($urandom);   f.saber_state = 2'($urandom);
        f.attack_x = 11'($urandom);  f.attack_y = 10'($urandom);
        return f;
    endfunction

    task automatic apply(input fields_t f);
        health = f.health;   rect_x = f.rect_x;   rect_y = f.rect_y;   rect_w = f.rect_w;
        rect_h = f.rect_h;   saber_x = f.saber_x; saber_y = f.saber_y;
        saber_state = f.saber_state; attack_x = f.attack_x; attack_y = f.attack_y;
    endtask

    // Triggers one frame, watches it to completion and checks the timing rules.
    task automatic do_frame(input string tag, input bit p2, input fields_t f,
                            input int disturb, output logic [88:0] word);
        bit pc, pd, ps, finished, done_at_rise, glitch, busy_bad, sck_bad;
        int cyc, low, rises, dones;
        use2 = p2;
        apply(f);
        word = '0; low = 0; rises = 0; dones = 0; finished = 0;
        done_at_rise = 0; glitch = 0; busy_bad = 0; sck_bad = 0;
        @(negedge clk_in);
        pc = m_clk; pd = m_data; ps = m_sel;
        if (p2) trig2 = 1'b1; else trig8 = 1'b1;
        cyc = 0;
        while (!finished && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
            trig2 = 1'b0; trig8 = 1'b0;
            if (cyc == disturb) begin
                if (p2) trig2 = 1'b1; else trig8 = 1'b1;
                apply(rand_fields());
            end
            if (m_done) dones++;
            if (m_busy === m_sel) busy_bad = 1;
            if (!m_sel) low++;
            if (!pc && m_clk) begin
                rises++;
                word = {word[87:0], m_data};
            end
            if (m_data !== pd && !(pc && !m_clk) && m_sel === ps) glitch = 1;
            if (m_sel !== ps && m_clk !== 1'b0) sck_bad = 1;
            if (!ps && m_sel) begin
                finished = 1;
                done_at_rise = m_done;
            end
            pc = m_clk; pd = m_data; ps = m_sel;
        end
        trig2 = 1'b0; trig8 = 1'b0;
        @(negedge clk_in);
        if (m_done) dones++;
        chk({tag, "_completed"}, finished, 1);
        chk({tag, "_sel_low"}, low, p2 ? 178 : 712);
        chk({tag, "_sck_rises"}, rises, 89);
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_done_at_sel_rise"}, done_at_rise, 1);
        chk({tag, "_data_only_on_fall"}, glitch, 0);
        chk({tag, "_busy_vs_sel"}, busy_bad, 0);
        chk({tag, "_sck_low_at_sel_edge"}, sck_bad, 0);
        chk({tag, "_word"}, word, model_frame(f));
    endtask

    initial begin
        vec_t        tbl[4];
        logic [88:0] w;
        fields_t     f;
        bit          bad;
        int          cnt, gap;

        tbl[0] = '{f: '{3'b101, 11'd0, 10'd0, 11'd0, 10'd0, 11'd0, 10'd0, 2'd0, 11'd0, 10'd0},
                   p2: 0, exp_ones: 2, exp_msb3: 3'b101};
        tbl[1] = '{f: '{3'd7, 11'd640, 10'd360, 11'd100, 10'd50, 11'd1023, 10'd719, 2'b10, 11'd5, 10'd9},
                   p2: 0, exp_ones: 37, exp_msb3: 3'b111};
        tbl[2] = '{f: '{3'h7, 11'h7FF, 10'h3FF, 11'h7FF, 10'h3FF, 11'h7FF, 10'h3FF, 2'h3, 11'h7FF, 10'h3FF},
                   p2: 1, exp_ones: 89, exp_msb3: 3'b111};
        tbl[3] = '{f: '{3'b010, 11'd0, 10'd0, 11'd0, 10'd0, 11'd0, 10'd0, 2'b01, 11'd0, 10'h3FF},
                   p2: 0, exp_ones: 12, exp_msb3: 3'b010};

        rst_in = 1'b1; trig8 = 1'b0; trig2 = 1'b0; use2 = 1'b0;
        apply(tbl[0].f);
        repeat (3) @(negedge clk_in);
        chk("reset_outputs_p8", {sel8, sck8, data8, busy8, done8}, 5'b10000);
        chk("reset_outputs_p2", {sel2, sck2, data2, busy2, done2}, 5'b10000);
        rst_in = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk_in);
            if (sel8 !== 1'b1 || sck8 !== 1'b0 || data8 !== 1'b0 || done8 !== 1'b0 ||
                sel2 !== 1'b1 || sck2 !== 1'b0 || data2 !== 1'b0 || done2 !== 1'b0) bad = 1;
        end
        chk("idle_1000_quiet", bad, 0);

        for (int i = 0; i < 4; i++) begin
            do_frame($sformatf("vec%0d", i), tbl[i].p2, tbl[i].f, 0, w);
            chk($sformatf("vec%0d_ones", i), $countones(w), tbl[i].exp_ones);
            chk($sformatf("vec%0d_msb3", i), w[88:86], tbl[i].exp_msb3);
            chk($sformatf("vec%0d_rect_x", i), w[85:75], tbl[i].f.rect_x);
            chk($sformatf("vec%0d_rect_y", i), w[74:65], tbl[i].f.rect_y);
            chk($sformatf("vec%0d_rect_w", i), w[64:54], tbl[i].f.rect_w);
            chk($sformatf("vec%0d_rect_h", i), w[53:44], tbl[i].f.rect_h);
            chk($sformatf("vec%0d_saber_x", i), w[43:33], tbl[i].f.saber_x);
            chk($sformatf("vec%0d_saber_y", i), w[32:23], tbl[i].f.saber_y);
            chk($sformatf("vec%0d_saber_state", i), w[22:21], tbl[i].f.saber_state);
            chk($sformatf("vec%0d_attack_x", i), w[20:10], tbl[i].f.attack_x);
            chk($sformatf("vec%0d_attack_y", i), w[9:0], tbl[i].f.attack_y);
        end

        for (int i = 0; i < 6; i++) begin
            do_frame($sformatf("rand%0d", i), (i % 3) == 2, rand_fields(), 0, w);
        end

        // Trigger plus field changes mid-frame must not disturb the frame in flight.
        do_frame("disturb", 0, rand_fields(), 100, w);

        // Trigger held high: exactly one idle cycle between frames.
        use2 = 0;
        apply(rand_fields());
        @(negedge clk_in);
        trig8 = 1'b1;
        cnt = 0;
        while (sel8 !== 1'b0 && cnt < 10) begin @(negedge clk_in); cnt++; end
        cnt = 0;
        while (sel8 !== 1'b1 && cnt < 1000) begin @(negedge clk_in); cnt++; end
        gap = 0;
        cnt = 0;
        while (sel8 === 1'b1 && cnt < 10) begin gap++; @(negedge clk_in); cnt++; end
        trig8 = 1'b0;
        chk("b2b_sel_high_gap", gap, 1);
        cnt = 0;
        while (sel8 !== 1'b1 && cnt < 1000) begin @(negedge clk_in); cnt++; end
        chk("b2b_second_frame_ends", sel8, 1);
        @(negedge clk_in);

        // Reset in the middle of a frame aborts it with no done pulse.
        apply(rand_fields());
        trig8 = 1'b1;
        @(negedge clk_in);
        trig8 = 1'b0;
        chk("midrst_frame_started", sel8, 0);
        repeat (299) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("midrst_outputs", {sel8, sck8, data8, busy8, done8}, 5'b10000);
        rst_in = 1'b0;
        bad = 0;
        repeat (800) begin
            @(negedge clk_in);
            if (done8 !== 1'b0 || sel8 !== 1'b1) bad = 1;
        end
        chk("midrst_no_done_no_resume", bad, 0);
        f = rand_fields();
        do_frame("post_rst", 0, f, 0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
